// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA-256 schedule types, sizes and sigma helpers
package sha_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2
  } sched_state_t;

  localparam int SHA256_BLOCK_WORDS = 16;
  localparam int SHA256_LOAD_BEATS  = 8;

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sha256_s0(input logic [31:0] x);
    return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sha256_s1(input logic [31:0] x);
    return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_schedule_if.sv
// rtl/sha256_msg_schedule_if.sv - padding-side and core-side handshake bundle
interface sha256_msg_schedule_if;
  logic [63:0] pad_word;
  logic        pad_msg_cmpl;
  logic        next_word;
  logic [31:0] w_out;
  logic        w_valid;
  logic [5:0]  w_round;
  logic        w_ready;
  logic        block_first;
  logic        block_last;

  modport master (
    input  pad_word, pad_msg_cmpl, w_ready,
    output next_word, w_out, w_valid, w_round, block_first, block_last
  );

  modport slave (
    output pad_word, pad_msg_cmpl, w_ready,
    input  next_word, w_out, w_valid, w_round, block_first, block_last
  );
endinterface

// File: rtl/sha256_w_next.sv
// rtl/sha256_w_next.sv - combinational W[t] from the four window taps
module sha256_w_next
  import sha_pkg::*;
(
  input  logic [31:0] w_m2,
  input  logic [31:0] w_m7,
  input  logic [31:0] w_m15,
  input  logic [31:0] w_m16,
  output logic [31:0] w_new
);

  assign w_new = sha256_s1(w_m2) + w_m7 + sha256_s0(w_m15) + w_m16;

endmodule

// File: rtl/sha256_msg_schedule.sv
// rtl/sha256_msg_schedule.sv - assembles 512-bit blocks and issues W[0..NUM_ROUNDS-1]
module sha256_msg_schedule
  import sha_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic msg_start,
  output logic busy,
  sha256_msg_schedule_if.master sif
);

  localparam logic [5:0] LAST_ROUND = 6'(NUM_ROUNDS - 1);
  localparam logic [2:0] LAST_BEAT  = 3'(SHA256_LOAD_BEATS - 1);

  sched_state_t state;
  logic [31:0]  window [SHA256_BLOCK_WORDS];
  logic [31:0]  w_new;
  logic [2:0]   load_cnt;
  logic [5:0]   round_cnt;
  logic         next_word_q;
  logic         w_valid_q;
  logic         first_flag;
  logic         last_flag;
  logic         first_round;

  // window[0] is always W[t]; the taps below therefore produce W[t+16]
  sha256_w_next u_w_next (
    .w_m2  (window[14]),
    .w_m7  (window[9]),
    .w_m15 (window[1]),
    .w_m16 (window[0]),
    .w_new (w_new)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      next_word_q <= 1'b0;
      w_valid_q   <= 1'b0;
      load_cnt    <= 3'd0;
      round_cnt   <= 6'd0;
      first_flag  <= 1'b0;
      last_flag   <= 1'b0;
      first_round <= 1'b0;
      for (int i = 0; i < SHA256_BLOCK_WORDS; i++) window[i] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (msg_start) begin
            state       <= LOAD;
            next_word_q <= 1'b1;
            first_flag  <= 1'b1;
            load_cnt    <= 3'd0;
          end
        end
        LOAD: begin
          for (int i = 0; i < SHA256_BLOCK_WORDS - 2; i++) window[i] <= window[i+2];
          window[SHA256_BLOCK_WORDS-2] <= sif.pad_word[63:32];
          window[SHA256_BLOCK_WORDS-1] <= sif.pad_word[31:0];
          if (load_cnt == LAST_BEAT) begin
            load_cnt    <= 3'd0;
            next_word_q <= 1'b0;
            w_valid_q   <= 1'b1;
            round_cnt   <= 6'd0;
            first_round <= 1'b1;
            state       <= ROUND;
          end else begin
            load_cnt <= load_cnt + 3'd1;
          end
        end
        ROUND: begin
          if (first_round) begin
            last_flag   <= sif.pad_msg_cmpl;
            first_round <= 1'b0;
          end
          if (sif.w_ready) begin
            for (int i = 0; i < SHA256_BLOCK_WORDS - 1; i++) window[i] <= window[i+1];
            window[SHA256_BLOCK_WORDS-1] <= w_new;
            if (round_cnt == LAST_ROUND) begin
              round_cnt <= 6'd0;
              w_valid_q <= 1'b0;
              if (last_flag) begin
                state <= IDLE;
              end else begin
                state       <= LOAD;
                next_word_q <= 1'b1;
                first_flag  <= 1'b0;
              end
            end else begin
              round_cnt <= round_cnt + 6'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.next_word   = next_word_q;
  assign sif.w_valid     = w_valid_q;
  assign sif.w_out       = window[0];
  assign sif.w_round     = round_cnt;
  assign sif.block_first = (state == ROUND) & first_flag;
  // last_flag is only captured on the first ROUND cycle, so pass the input through then
  assign sif.block_last  = (state == ROUND) & (first_round ? sif.pad_msg_cmpl : last_flag);
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// tb/tb_sha256_msg_schedule.sv - self-checking bench for sha256_msg_schedule
module tb_sha256_msg_schedule;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic msg_start = 1'b0;
  logic busy;

  sha256_msg_schedule_if sif ();

  sha256_msg_schedule #(.NUM_ROUNDS(64)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .msg_start (msg_start),
    .busy      (busy),
    .sif       (sif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] blk  [16];
  logic [31:0] refw [64];
  logic [31:0] data [27];
  bit chk_abc = 1'b0;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void build_ref();
    for (int t = 0; t < 16; t++) refw[t] = blk[t];
    for (int t = 16; t < 64; t++)
      refw[t] = (rr(refw[t-2], 17) ^ rr(refw[t-2], 19) ^ (refw[t-2] >> 10)) + refw[t-7]
              + (rr(refw[t-15], 7) ^ rr(refw[t-15], 18) ^ (refw[t-15] >> 3)) + refw[t-16];
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check(tag, 64'({sif.next_word, sif.w_valid, sif.block_first, sif.block_last, busy,
                    sif.w_round, sif.w_out}), 64'd0);
  endtask

  task automatic start_msg();
    @(negedge clk);
    msg_start = 1'b1;
    @(negedge clk);
    msg_start = 1'b0;
    check("start_latency", 64'(sif.next_word), 64'd1);
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic abort_now(input string tag);
    reset_n = 1'b0;
    #1;
    check_reset_outs(tag);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("post_abort_idle", 64'({busy, sif.w_valid, sif.next_word}), 64'd0);
  endtask

  // mode: 0 plain, 1 random stalls, 2 stray msg_start, 3 reset mid-LOAD, 4 reset mid-ROUND
  task automatic do_block(input bit is_first, input bit is_last, input int mode);
    int t;
    int guard;
    bit hs;
    build_ref();
    sif.pad_msg_cmpl = is_last;
    guard = 0;
    while (!sif.next_word && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("load_wait", 64'(sif.next_word), 64'd1);
    for (int k = 0; k < 8; k++) begin
      if (mode == 3 && k == 4) begin
        abort_now("abort_load");
        return;
      end
      check("next_word_load", 64'(sif.next_word), 64'd1);
      check("no_valid_in_load", 64'(sif.w_valid), 64'd0);
      sif.pad_word = {blk[2*k], blk[2*k+1]};
      msg_start = (mode == 2 && k == 3);
      @(negedge clk);
    end
    msg_start = 1'b0;
    check("next_word_drop", 64'(sif.next_word), 64'd0);
    t = 0;
    guard = 0;
    while (t < 64 && guard < 1000) begin
      if (mode == 4 && t == 30) begin
        abort_now("abort_round");
        return;
      end
      sif.w_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      msg_start = (mode == 2 && t == 20);
      check("w_valid", 64'(sif.w_valid), 64'd1);
      check("w_round", 64'(sif.w_round), 64'(t));
      check("w_out", 64'(sif.w_out), 64'(refw[t]));
      check("block_first", 64'(sif.block_first), 64'(is_first));
      check("block_last", 64'(sif.block_last), 64'(is_last));
      check("no_next_word_round", 64'(sif.next_word), 64'd0);
      if (chk_abc && t == 0)  check("abc_w0", 64'(sif.w_out), 64'h61626380);
      if (chk_abc && t == 15) check("abc_w15", 64'(sif.w_out), 64'h00000018);
      if (chk_abc && t == 16) check("abc_w16", 64'(sif.w_out), 64'h61626380);
      if (chk_abc && t == 17) check("abc_w17", 64'(sif.w_out), 64'h000F0000);
      hs = sif.w_ready;
      @(negedge clk);
      guard++;
      if (hs) t++;
    end
    msg_start = 1'b0;
    sif.w_ready = 1'b1;
    check("handshakes", 64'(t), 64'd64);
    check("w_valid_drop", 64'(sif.w_valid), 64'd0);
    if (is_last) check("idle_after_block", 64'(busy), 64'd0);
    else         check("reload_after_block", 64'(sif.next_word), 64'd1);
  endtask

  initial begin
    sif.pad_word = 64'd0;
    sif.pad_msg_cmpl = 1'b0;
    sif.w_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outs("reset_state");
    reset_n = 1'b1;
    @(negedge clk);

    // "abc" single block
    set_abc();
    chk_abc = 1'b1;
    start_msg();
    do_block(1'b1, 1'b1, 0);
    chk_abc = 1'b0;

    // two-block 56-byte message
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
            32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
            32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    start_msg();
    do_block(1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[15] = 32'h000001c0;
    do_block(1'b0, 1'b1, 0);

    // random data with downstream stalls
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    start_msg();
    do_block(1'b1, 1'b1, 1);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    start_msg();
    do_block(1'b1, 1'b0, 1);
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    do_block(1'b0, 1'b1, 1);

    // stray msg_start in LOAD and ROUND
    set_abc();
    chk_abc = 1'b1;
    start_msg();
    do_block(1'b1, 1'b1, 2);

    // resets mid-LOAD and mid-ROUND, then a clean rerun
    start_msg();
    do_block(1'b1, 1'b1, 3);
    start_msg();
    do_block(1'b1, 1'b1, 4);
    start_msg();
    do_block(1'b1, 1'b1, 0);
    chk_abc = 1'b0;

    // 108-byte message as sha_padding would deliver it
    for (int i = 0; i < 27; i++) data[i] = $urandom;
    for (int i = 0; i < 16; i++) blk[i] = data[i];
    start_msg();
    do_block(1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    for (int i = 0; i < 11; i++) blk[i] = data[16+i];
    blk[11] = 32'h80000000;
    blk[15] = 32'h00000360;
    do_block(1'b0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
